// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader packing bytes big-endian into the CPU RAM image.
// Optional checksum trailer byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int RAM_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [RAM_SIZE*32-1:0] ram_flat,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7:0]            words_loaded,
  output logic                  cks_err
);

  localparam logic [10:0] MAX_B = 11'(RAM_SIZE * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [9:0]              bidx_q, bidx_d;
  logic                    sat_q, sat_d;
  logic [31:0]             wbuf_q, wbuf_d;
  logic [RAM_SIZE*32-1:0]  ram_q, ram_d;
  logic [7:0]              words_q, words_d;
  logic                    ovf_q, ovf_d;

  logic                    is_data;
  logic                    in_range;
  logic [31:0]             merged;
  logic                    wr_en;
  logic [31:0]             wr_word;
  logic [7:0]              wr_idx;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic                    cks_q, cks_d;
  logic [7:0]              sum_q, sum_d;
`endif

  // Next-state, byte packing and word write decisions
  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    sat_d    = sat_q;
    wbuf_d   = wbuf_q;
    words_d  = words_q;
    ovf_d    = ovf_q;
    is_data  = 1'b1;
    in_range = !sat_q && ({1'b0, bidx_q} < MAX_B);
    merged   = wbuf_q;
    wr_en    = 1'b0;
    wr_word  = '0;
    wr_idx   = bidx_q[9:2];
`ifdef PROG_LOADER_CHECKSUM_EN
    cks_d    = cks_q;
    sum_d    = sum_q;
    is_data  = !in_last;
`endif

    unique case (bidx_q[1:0])
      2'd0: merged[31:24] = in_data;
      2'd1: merged[23:16] = in_data;
      2'd2: merged[15:8]  = in_data;
      2'd3: merged[7:0]   = in_data;
    endcase

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          bidx_d  = '0;
          sat_d   = 1'b0;
          wbuf_d  = '0;
          words_d = '0;
          ovf_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          cks_d   = 1'b0;
          sum_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (is_data) begin
            if (in_range) begin
              if (bidx_q[1:0] == 2'd3 || in_last) begin
                wr_en   = 1'b1;
                wr_word = merged;
                wbuf_d  = '0;
              end else begin
                wbuf_d  = merged;
              end
            end else begin
              ovf_d = 1'b1;
            end
            if (bidx_q == 10'h3FF) sat_d = 1'b1;
            else bidx_d = bidx_q + 10'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d = sum_q + in_data;
`endif
          end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            // Checksum byte: flush any pending partial word, then verify
            if (in_range && bidx_q[1:0] != 2'd0) begin
              wr_en   = 1'b1;
              wr_word = wbuf_q;
              wbuf_d  = '0;
            end
            cks_d = (sum_q + in_data) != 8'h00;
`endif
          end
          if (in_last) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en && words_q != 8'hFF) words_d = words_q + 8'd1;
  end

  // RAM image update for the selected word
  always_comb begin
    ram_d = ram_q;
    for (int i = 0; i < RAM_SIZE; i++) begin
      if (wr_en && int'(wr_idx) == i) ram_d[i*32 +: 32] = wr_word;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      bidx_q  <= '0;
      sat_q   <= 1'b0;
      wbuf_q  <= '0;
      ram_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      cks_q   <= 1'b0;
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      sat_q   <= sat_d;
      wbuf_q  <= wbuf_d;
      ram_q   <= ram_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      cks_q   <= cks_d;
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign busy         = (state_q == S_LOAD);
  assign done         = (state_q == S_DONE);
  assign cpu_reset    = (state_q != S_DONE);
  assign ram_flat     = ram_q;
  assign words_loaded = words_q;
  assign overflow     = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign cks_err      = cks_q;
`else
  assign cks_err      = 1'b0;
`endif

endmodule
